// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the sequence
// detector bench: FSM state encoding and default pattern sizing.
package serial_pattern_gen_pkg;

    localparam int unsigned SPG_WIDTH = 8;  // default maximum pattern length
    localparam int unsigned SPG_LW    = 3;  // default len field width, clog2(SPG_WIDTH)
    localparam int unsigned SPG_CNT_W = 4;  // width of reps / gap fields

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } spg_state_e;

endpackage : serial_pattern_gen_pkg

// File: rtl/spg_shift_reg.sv
// Load/shift-left pattern register with a count-down bit index.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_load     - load i_data aligned so bit i_len lands in the MSB
//   i_shift    - shift left one place, decrement index (saturates at 0)
//   i_clear    - zero register and index (highest priority)
//   i_data     - pattern to load
//   i_len      - pattern length minus one
//   o_msb      - current serial bit (register MSB)
//   o_last     - index has reached bit 0
module spg_shift_reg
    import serial_pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = SPG_WIDTH,
    parameter int unsigned LW    = SPG_LW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    input  logic [LW-1:0]    i_len,
    output logic             o_msb,
    output logic             o_last
);

    logic [WIDTH-1:0] r_sh;
    logic [LW-1:0]    r_idx;
    logic [LW-1:0]    w_align;

    // Left-align so pattern[len] sits in the MSB; lower bits fill with zeros,
    // so shifting past bit 0 naturally presents 0.
    assign w_align = LW'(WIDTH - 1) - i_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_sh  <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_sh  <= i_data << w_align;
            r_idx <= i_len;
        end else if (i_shift) begin
            r_sh  <= r_sh << 1;
            if (r_idx != '0) begin
                r_idx <= r_idx - LW'(1);
            end
        end
    end

    assign o_msb  = r_sh[WIDTH-1];
    assign o_last = (r_idx == '0);

endmodule : spg_shift_reg

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: sends pattern[len..0] MSB-first, repeated
// reps+1 times with gap idle cycles between repetitions, then pulses done.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin a transaction (honoured only in IDLE)
//   abort             - cancel an active transaction (SEND/GAP only)
//   pattern, len      - bits to send and length minus one
//   reps, gap         - extra repetitions and idle cycles between them
//   x, valid          - serial bit and its qualifier
//   busy, done        - not-idle flag and end-of-transaction pulse
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = SPG_WIDTH,
    parameter int unsigned LW    = SPG_LW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     pattern,
    input  logic [LW-1:0]        len,
    input  logic [SPG_CNT_W-1:0] reps,
    input  logic [SPG_CNT_W-1:0] gap,
    output logic                 x,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    spg_state_e           r_state;
    spg_state_e           w_next;
    logic [WIDTH-1:0]     r_pat;
    logic [LW-1:0]        r_len;
    logic [SPG_CNT_W-1:0] r_gap;
    logic [SPG_CNT_W-1:0] r_rep_cnt;
    logic [SPG_CNT_W-1:0] r_gap_cnt;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_latch;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_clear;
    logic                 w_rep_dec;
    logic                 w_gap_load;
    logic                 w_gap_dec;
    logic                 w_last;
    logic                 w_msb;
    logic [WIDTH-1:0]     w_ld_data;
    logic [LW-1:0]        w_ld_len;

    // First repetition loads straight from the inputs; later ones from the latched copy.
    assign w_ld_data = w_latch ? pattern : r_pat;
    assign w_ld_len  = w_latch ? len     : r_len;

    spg_shift_reg #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_data  (w_ld_data),
        .i_len   (w_ld_len),
        .o_msb   (w_msb),
        .o_last  (w_last)
    );

    // Next-state and datapath control.
    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_clear    = 1'b0;
        w_rep_dec  = 1'b0;
        w_gap_load = 1'b0;
        w_gap_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next  = ST_SEND;
                    w_latch = 1'b1;
                    w_load  = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end else if (!w_last) begin
                    w_shift = 1'b1;
                end else if (r_rep_cnt != '0) begin
                    w_rep_dec = 1'b1;
                    if (r_gap != '0) begin
                        w_next     = ST_GAP;
                        w_clear    = 1'b1;
                        w_gap_load = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end else begin
                    w_next  = ST_DONE;
                    w_clear = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end else if (r_gap_cnt == SPG_CNT_W'(1)) begin
                    w_next = ST_SEND;
                    w_load = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next  = ST_IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    // State, latched fields, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_gap     <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_pat     <= pattern;
                r_len     <= len;
                r_gap     <= gap;
                r_rep_cnt <= reps;
            end else if (w_rep_dec) begin
                r_rep_cnt <= r_rep_cnt - SPG_CNT_W'(1);
            end
            if (w_gap_load) begin
                r_gap_cnt <= r_gap;
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - SPG_CNT_W'(1);
            end
            r_valid <= (w_next == ST_SEND);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    assign x     = w_msb;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : serial_pattern_gen

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen. Expected per-cycle output words
// {busy,done,valid,x} are queued when a transaction is started and checked
// on every falling edge; an empty queue means the block must be idle.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       mon_en   = 1'b0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    serial_pattern_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected output words for one transaction, starting with the cycle in
    // which start is still being sampled.
    task automatic push_txn(input logic [7:0] p, input int l, input int r, input int g);
        logic [7:0] pv;
        pv = p;
        exp_q.push_back(4'b0000);
        for (int k = 0; k <= r; k++) begin
            for (int i = l; i >= 0; i--) exp_q.push_back({3'b101, pv[i]});
            if (k < r) for (int j = 0; j < g; j++) exp_q.push_back(4'b1000);
        end
        exp_q.push_back(4'b1100);
    endtask

    // Cycle-by-cycle output monitor.
    always @(negedge clk) begin
        logic [3:0] e;
        if (mon_en) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
            chk("out{busy,done,valid,x}", {28'd0, busy, done, valid, x}, {28'd0, e});
        end
    end

    // Called at posedge+1; start is sampled at the following edge.
    task automatic start_txn(input logic [7:0] p, input int l, input int r, input int g);
        pattern = p;
        len     = 3'(l);
        reps    = 4'(r);
        gap     = 4'(g);
        start   = 1'b1;
        push_txn(p, l, r, g);
        @(posedge clk); #1;
        start   = 1'b0;
        pattern = 8'($urandom);
        len     = 3'($urandom);
        reps    = 4'($urandom);
        gap     = 4'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Outputs change at the next edge, so only the word already due survives.
    task automatic truncate_q();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; reps = '0; gap = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic 101, repeated with gaps, back-to-back full width.
        start_txn(8'h05, 2, 0, 0); wait_idle();
        start_txn(8'h05, 2, 2, 2); wait_idle();
        start_txn(8'hA5, 7, 1, 0); wait_idle();

        // Start with a different pattern while busy is ignored.
        start_txn(8'h05, 2, 1, 1);
        @(posedge clk); #1;
        start = 1'b1; pattern = 8'hFF; len = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Abort on the second bit, then a normal transaction.
        start_txn(8'hB3, 5, 0, 0);
        @(posedge clk); #1;
        abort = 1'b1;
        truncate_q();
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle();
        start_txn(8'h05, 2, 0, 0); wait_idle();

        // Reset (with start held) during GAP, then a full sequence.
        start_txn(8'h05, 2, 1, 3);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        truncate_q();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        start_txn(8'h05, 2, 1, 3); wait_idle();

        // Abort together with start in IDLE: start wins.
        abort = 1'b1;
        start_txn(8'h6C, 4, 1, 1);
        abort = 1'b0;
        wait_idle();

        // Start held high: second transaction in the first IDLE cycle after DONE.
        pattern = 8'h05; len = 3'd2; reps = 4'd0; gap = 4'd0;
        start = 1'b1;
        push_txn(8'h05, 2, 0, 0);
        push_txn(8'h05, 2, 0, 0);
        repeat (7) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // Abort during the DONE cycle has no effect.
        start_txn(8'h01, 0, 0, 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle();

        // A handful of random transactions.
        for (int t = 0; t < 6; t++) begin
            start_txn(8'($urandom), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            wait_idle();
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_serial_pattern_gen

// File: doc/serial_pattern_gen.md
SERIAL_PATTERN_GEN -- requirements
Module: serial_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter LW, default 3: width of len field, equal to clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin transmission, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of an active transmission.
REQ-007 SHALL have port pattern  input  WIDTH  bits to transmit, MSB-first from bit index len.
REQ-008 SHALL have port len  input  LW  pattern length minus one (0 -> 1 bit, 7 -> 8 bits).
REQ-009 SHALL have port reps  input  4  extra repetitions (0 -> sent once, 15 -> sent 16 times).
REQ-010 SHALL have port gap  input  4  idle cycles inserted between repetitions.
REQ-011 SHALL have port x  output  1  serial data bit, drives detector input x.
REQ-012 SHALL have port valid  output  1  high while x carries a pattern bit.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final bit of the final repetition.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, SEND, GAP, DONE; x, valid, busy and done SHALL be registered outputs.
REQ-016 In IDLE with start=1 at edge k, SHALL latch pattern, len, reps and gap, and enter SEND; the first bit, pattern[len], SHALL appear on x with valid=1 in cycle k+1.
REQ-017 SEND SHALL output one bit per cycle, in order pattern[len] down to pattern[0], from the latched copy; input changes during busy SHALL have no effect.
REQ-018 After bit 0: if repetitions remain and gap>0, SHALL go to GAP for exactly gap cycles with x=0, valid=0, then return to SEND.
REQ-019 After bit 0: if repetitions remain and gap=0, the next repetition's first bit SHALL follow in the next cycle with no bubble.
REQ-020 After bit 0 of the last repetition, SHALL enter DONE for exactly one cycle (done=1, valid=0, x=0, busy=1), then go to IDLE.
REQ-021 Total valid cycles per transaction SHALL equal (len+1)*(reps+1).
REQ-022 start while busy=1 SHALL be ignored; start in the DONE cycle SHALL also be ignored.
REQ-023 start=1 held continuously SHALL begin a new transaction in the first IDLE cycle after DONE.
REQ-024 abort=1 in SEND or GAP SHALL force IDLE at the next edge with done not asserted; abort in IDLE or DONE SHALL have no effect.
REQ-025 abort and start together in IDLE: abort SHALL be ignored and start SHALL be honoured.
REQ-026 The bit index counter SHALL decrement from len to 0 without wrap; the repetition counter SHALL decrement from reps to 0; the gap counter SHALL count gap down to 1.

Reset
REQ-027 rst=1 SHALL, at the next edge, force state IDLE and x=0, valid=0, busy=0, done=0, and clear all counters and latched fields.
REQ-028 rst SHALL take priority over start and abort, including mid-transmission.
REQ-029 Operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, SEND, GAP, DONE; 2-bit) and the default WIDTH/LW constants used by both this block and the sequence detector bench.
REQ-031 The datapath SHALL use one sub-module, spg_shift_reg: a WIDTH-bit load/shift-left register with a count-down bit index, controlled by the FSM.

Verification
REQ-032 pattern=8'b0000_0101, len=2, reps=0, gap=0, start at cycle 0 -> x=1,0,1 valid=1 in cycles 1-3, done=1 in cycle 4, busy=0 in cycle 5; a connected 101 detector reports y=1 once.
REQ-033 Same pattern, reps=2, gap=2 -> x/valid = 101, 00 (valid=0), 101, 00, 101, then done; 9 valid cycles.
REQ-034 pattern=8'hA5, len=7, reps=1, gap=0 -> 16 contiguous valid bits 1010_0101_1010_0101, then done.
REQ-035 start pulsed at cycle 2 of an active transaction with a different pattern -> ignored; output is unchanged and done is asserted exactly once.
REQ-036 abort at the 2nd bit of SEND -> IDLE next cycle, valid=0, done never asserted; a new start then transmits normally.
REQ-037 rst asserted during GAP -> all outputs 0 at the next edge; start after rst deasserts produces the full sequence from the first bit.
